// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: serial line into the receiver and byte strobes out of it
interface uart_rx_byte_if;
    logic       rx;
    logic       rok;
    logic [7:0] mosi;
    logic       frame_err;
    logic       rx_busy;
    modport master (output rx, input rok, mosi, frame_err, rx_busy);
    modport slave  (input rx, output rok, mosi, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, centre-sampled, emits one-cycle byte and framing-error strobes
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input logic           clk,
    input logic           rst,
    uart_rx_byte_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       shreg, shreg_nx, mosi_nx;
    logic             rx_m, rx_s, rok_nx, ferr_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            bus.mosi      <= '0;
            bus.rok       <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.rx_busy   <= 1'b0;
        end else begin
            rx_m          <= bus.rx;
            rx_s          <= rx_m;
            state         <= state_nx;
            cnt           <= cnt_nx;
            bit_idx       <= bit_idx_nx;
            shreg         <= shreg_nx;
            bus.mosi      <= mosi_nx;
            bus.rok       <= rok_nx;
            bus.frame_err <= ferr_nx;
            bus.rx_busy   <= state_nx != IDLE;
        end
    end
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CNT_W'(1);
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        mosi_nx    = bus.mosi;
        rok_nx     = 1'b0;
        ferr_nx    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx   = '0;
                state_nx = rx_s ? IDLE : START;
            end
            START: if (cnt == HALF) begin
                // a start bit that is high again at its centre was only a glitch
                state_nx   = rx_s ? IDLE : DATA;
                cnt_nx     = '0;
                bit_idx_nx = '0;
            end
            DATA: if (cnt == FULL) begin
                shreg_nx   = {rx_s, shreg[7:1]};
                cnt_nx     = '0;
                bit_idx_nx = bit_idx + 3'd1;
                state_nx   = (bit_idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt == FULL) begin
                cnt_nx   = '0;
                rok_nx   = rx_s;
                ferr_nx  = !rx_s;
                mosi_nx  = rx_s ? shreg : bus.mosi;
                state_nx = rx_s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                cnt_nx   = '0;
                state_nx = rx_s ? IDLE : WAIT_IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receive front end. Converts the serial line into byte strobes that feed the frame parser: `rok` is a one-cycle strobe and `mosi` is the received byte.
- Fixed frame format 8N1, LSB first, idle high.
- Bit timing comes from a clock-cycle count per bit; each bit is sampled once at its centre.
- Framing errors and start-bit glitches are rejected, so the parser never sees a bad byte.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per bit (50 MHz / 115200). Legal range 4 to 65535.
- CNT_W, 16: width of the bit-timing counter. Must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- rok  output  1  one-cycle strobe: `mosi` holds a newly received valid byte.
- mosi  output  8  last valid received byte; held until the next valid byte.
- frame_err  output  1  one-cycle strobe: stop bit sampled low; byte discarded.
- rx_busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: `rok`=0, `frame_err`=0, `mosi`=8'h00, `rx_busy`=0.
  - State IDLE; counter, bit index and shift register cleared.
  - Synchronizer flops reset to 1, so no false start after reset.
  - Reset asserted mid-frame aborts the frame with no strobe.
- Input sync: `rx` passes through 2 flops to give `rx_s`. Only `rx_s` is used internally.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - `rx_s`==0 -> START, counter=0.
- START:
  - Counter increments each cycle.
  - At counter == CLKS_PER_BIT/2-1 (integer division), sample `rx_s`.
  - Sample 0 -> DATA, counter=0, bit_idx=0.
  - Sample 1 -> IDLE. This is a glitch: no strobe, no error.
- DATA:
  - At counter == CLKS_PER_BIT-1, sample `rx_s` into the shift register, LSB first (shift right, new bit into bit 7).
  - Counter resets to 0 and bit_idx increments.
  - After the sample with bit_idx==7 -> STOP.
- STOP:
  - At counter == CLKS_PER_BIT-1, sample `rx_s`.
  - Sample 1: `mosi` <= shift register; `rok`=1 for exactly the next cycle; -> IDLE.
  - Sample 0: `frame_err`=1 for exactly the next cycle; `mosi` unchanged; -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until `rx_s`==1, then -> IDLE.
  - A line held low (break) yields one `frame_err` and nothing else.
- `rok` and `frame_err` are never high together and never high for two consecutive cycles.
- Back-to-back frames are accepted: IDLE is re-entered before the next start edge, because the stop sample sits at mid-stop-bit.
- Latency: the strobe is asserted 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the falling edge on `rx`, ±1 cycle for synchronizer phase.
- `rx_busy` = (state != IDLE), registered with the state.

Test Plan:
- CLKS_PER_BIT=16; send 0xA5 with a valid stop -> exactly one `rok` pulse; `mosi`=8'hA5; `frame_err` stays 0; `rok` falls 2+8+144+1 (±1) cycles after the start edge.
- `rx` low for 4 cycles, then high -> START aborts to IDLE; no `rok`, no `frame_err`; `rx_busy` drops within 10 cycles.
- Send 0x3C with the stop bit forced low, line held low for 40 more bit times -> one `frame_err` pulse; `mosi` keeps its prior value; no re-trigger until the line returns high.
- Back-to-back 0x00, 0xFF, 0x05 with no idle gap -> three `rok` pulses with `mosi`=00, FF, 05 in order; no errors.
- Assert `rst` for 1 cycle at the 4th data bit of 0x77, then send 0x12 -> no strobe for 0x77; `mosi` reads 00 after reset; 0x12 is then received correctly.
- CLKS_PER_BIT=434, parser-format stream 00 02 03 -> three strobes, bytes in order, each strobe exactly 1 cycle wide.
